// File: rtl/reader_r1_pkg.sv
// Shared definitions for the reader_r1 host-command reader: controller
// state encoding, command-word field positions and status-word layout.
package reader_r1_pkg;

    localparam int WORD_W  = 32;
    localparam int TAG_BIT = 31;
    localparam int OPC_MSB = 30;
    localparam int OPC_LSB = 24;
    localparam int PAY_MSB = 23;
    localparam int PAY_LSB = 0;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // Status word: {ack_tag, overrun, 14'b0, cmd_count[15:0]}
    function automatic logic [WORD_W-1:0] pack_status(input logic ack_tag,
                                                      input logic overrun,
                                                      input logic [CNT_W-1:0] count);
        pack_status = {ack_tag, overrun, 14'b0, count};
    endfunction

endpackage

// File: rtl/stable_sampler.sv
// Stability checker: holds a snapshot of the host word and counts how many
// consecutive samples have matched it since the last capture.
module stable_sampler
    import reader_r1_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              capture,
    input  logic              settle,
    output logic [WORD_W-1:0] snapshot,
    output logic              match,
    output logic              stable
);

    localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

    logic [WORD_W-1:0] snap_q, snap_d;
    logic [3:0]        cnt_q,  cnt_d;

    // Match/stable decode and next snapshot/counter values
    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        match  = (word_in == snap_q);
        stable = match && (cnt_q == LAST_CNT);
        if (capture) begin
            snap_d = word_in;
            cnt_d  = 4'd0;
        end else if (settle && match && !stable) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Snapshot and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign snapshot = snap_q;

endmodule

// File: rtl/reader_r1.sv
// Host command reader: detects a tag toggle on the host command register,
// waits for the word to settle, presents it to the consumer with a
// valid/ready handshake and writes back an acknowledge status word.
module reader_r1
    import reader_r1_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] register_1,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_opcode,
    output logic [23:0] cmd_payload,
    output logic        we_status,
    output logic [31:0] status_data
);

    state_t            state_q, state_d;
    logic              last_tag_q, last_tag_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  cmd_count_q, cmd_count_d;
    logic [WORD_W-1:0] status_q, status_d;

    logic              capture;
    logic              settle;
    logic [WORD_W-1:0] snapshot;
    logic              match;
    logic              stable;

    stable_sampler #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .word_in  (register_1),
        .capture  (capture),
        .settle   (settle),
        .snapshot (snapshot),
        .match    (match),
        .stable   (stable)
    );

    // Next-state, handshake and status update logic
    always_comb begin
        state_d     = state_q;
        last_tag_d  = last_tag_q;
        overrun_d   = overrun_q;
        cmd_count_d = cmd_count_q;
        status_d    = status_q;
        capture     = 1'b0;
        settle      = 1'b0;
        cmd_valid   = 1'b0;
        we_status   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (register_1[TAG_BIT] != last_tag_q) begin
                    capture = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (register_1[TAG_BIT] == last_tag_q) begin
                    // Host retracted the toggle before it settled.
                    state_d = ST_IDLE;
                end else if (!match) begin
                    // Torn write: restart the stability window on the new word.
                    capture = 1'b1;
                end else begin
                    settle = 1'b1;
                    if (stable) begin
                        state_d = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                cmd_valid = 1'b1;
                if (!match) begin
                    overrun_d = 1'b1;
                end
                if (cmd_ready) begin
                    // Status is committed on the handshake edge so the ACK
                    // cycle already shows the new tag and count.
                    state_d     = ST_ACK;
                    last_tag_d  = snapshot[TAG_BIT];
                    cmd_count_d = cmd_count_q + 16'd1;
                    status_d    = pack_status(last_tag_d, overrun_d, cmd_count_d);
                end
            end
            ST_ACK: begin
                we_status = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_tag_q  <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_count_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_tag_q  <= last_tag_d;
            overrun_q   <= overrun_d;
            cmd_count_q <= cmd_count_d;
            status_q    <= status_d;
        end
    end

    assign cmd_opcode  = snapshot[OPC_MSB:OPC_LSB];
    assign cmd_payload = snapshot[PAY_MSB:PAY_LSB];
    assign status_data = status_q;

endmodule
